// File: rtl/icache_nway_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_nway_if
// Purpose  : Fetch-side and read-bus signal bundle for icache_nway.
//            slave  : the cache's view of the bundle.
//            master : the environment's view (CPU fetch stage plus read bus).
// Signals  : inst_rreq/inst_addr/uncached  fetch request (to cache)
//            inst_valid/inst_out           fetch response (from cache)
//            inv_req/inv_done              invalidate-all handshake
//            cpu_ren/cpu_raddr             bus read request (from cache)
//            dev_rrdy/dev_rvalid/dev_rdata bus acceptance and read data
// Revision : 1.0 - initial release
// ============================================================================
interface icache_nway_if #(
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 128
);
  logic                 inst_rreq;
  logic [ADDR_W-1:0]    inst_addr;
  logic                 uncached;
  logic                 inst_valid;
  logic [31:0]          inst_out;
  logic                 inv_req;
  logic                 inv_done;
  logic                 dev_rrdy;
  logic [3:0]           cpu_ren;
  logic [ADDR_W-1:0]    cpu_raddr;
  logic                 dev_rvalid;
  logic [LINE_BITS-1:0] dev_rdata;

  modport slave (
    input  inst_rreq, inst_addr, uncached, inv_req, dev_rrdy, dev_rvalid, dev_rdata,
    output inst_valid, inst_out, inv_done, cpu_ren, cpu_raddr
  );

  modport master (
    output inst_rreq, inst_addr, uncached, inv_req, dev_rrdy, dev_rvalid, dev_rdata,
    input  inst_valid, inst_out, inv_done, cpu_ren, cpu_raddr
  );
endinterface
`default_nettype wire

// File: rtl/icache_nway.sv
`default_nettype none
// ============================================================================
// Module   : icache_nway
// Purpose  : N-way set-associative L1 instruction cache with flop-based
//            tag/valid/data arrays, per-set round-robin replacement,
//            whole-cache invalidate and an uncached-fetch bypass.
// Ports    : cpu_clk_i  clock, rising edge
//            cpu_rst_i  synchronous active-high reset
//            bus        icache_nway_if.slave (fetch, invalidate, read bus)
// Revision : 1.0 - initial release
// ============================================================================
module icache_nway #(
  parameter int WAYS      = 2,
  parameter int SETS      = 64,
  parameter int LINE_BITS = 128,
  parameter int ADDR_W    = 32
) (
  input  logic             cpu_clk_i,
  input  logic             cpu_rst_i,
  icache_nway_if.slave     bus
);

  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WS_W  = OFF_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MISS_REQ  = 3'd2,
    S_MISS_WAIT = 3'd3,
    S_RESP      = 3'd4,
    S_INVAL     = 3'd5
  } state_t;

  state_t                state_q;
  // Word address of the accepted fetch; bits [1:0] are always zero so not kept.
  logic [ADDR_W-1:2]     addr_q;
  logic                  unc_q;
  logic                  inst_valid_q;
  logic [31:0]           inst_out_q;
  logic                  inv_done_q;
  logic [3:0]            cpu_ren_q;
  logic [ADDR_W-1:0]     cpu_raddr_q;

  logic [SETS-1:0]       valid_q [WAYS];
  logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
  logic [LINE_BITS-1:0]  data_q  [WAYS][SETS];
  logic [WAY_W-1:0]      rr_q    [SETS];

  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_idx;
  logic [WS_W-1:0]       w_wsel;
  logic                  w_hit;
  logic [LINE_BITS-1:0]  w_hit_line;
  logic                  w_has_inv;
  logic [WAY_W-1:0]      w_victim;
  logic [31:0]           w_hit_word;
  logic [31:0]           w_fill_word;

  assign w_tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign w_idx  = addr_q[OFF_W +: IDX_W];
  assign w_wsel = addr_q[2 +: WS_W];

  // Tags are unique within a set, so at most one way can match.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][w_idx] && (tag_q[w][w_idx] == w_tag)) begin
        w_hit      = 1'b1;
        w_hit_line = data_q[w][w_idx];
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way is the final winner.
  always_comb begin
    w_has_inv = 1'b0;
    w_victim  = rr_q[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][w_idx]) begin
        w_has_inv = 1'b1;
        w_victim  = WAY_W'(w);
      end
    end
  end

  assign w_hit_word  = w_hit_line[w_wsel * 32 +: 32];
  assign w_fill_word = bus.dev_rdata[w_wsel * 32 +: 32];

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      unc_q        <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inv_done_q   <= 1'b0;
      cpu_ren_q    <= 4'h0;
      cpu_raddr_q  <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      inst_valid_q <= 1'b0;
      inv_done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // inv_req is still high in the cycle inv_done is seen; do not
          // start a second invalidate for the same request.
          if (bus.inv_req && !inv_done_q) begin
            state_q <= S_INVAL;
          end else if (bus.inst_rreq) begin
            addr_q <= bus.inst_addr[ADDR_W-1:2];
            unc_q  <= bus.uncached;
            if (bus.uncached) begin
              cpu_ren_q   <= 4'hF;
              cpu_raddr_q <= bus.inst_addr;
              state_q     <= S_MISS_REQ;
            end else begin
              state_q <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            inst_out_q   <= w_hit_word;
            inst_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cpu_ren_q   <= 4'hF;
            cpu_raddr_q <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            state_q     <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (bus.dev_rrdy) begin
            cpu_ren_q <= 4'h0;
            state_q   <= S_MISS_WAIT;
          end
        end
        S_MISS_WAIT: begin
          if (bus.dev_rvalid) begin
            if (unc_q) begin
              inst_out_q <= bus.dev_rdata[31:0];
            end else begin
              valid_q[w_victim][w_idx] <= 1'b1;
              tag_q[w_victim][w_idx]   <= w_tag;
              data_q[w_victim][w_idx]  <= bus.dev_rdata;
              // Pointer only advances when a valid line is displaced.
              if ((WAYS > 1) && !w_has_inv) rr_q[w_idx] <= w_victim + 1'b1;
              inst_out_q <= w_fill_word;
            end
            inst_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        S_INVAL: begin
          for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
          for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
          inv_done_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_out   = inst_out_q;
  assign bus.inv_done   = inv_done_q;
  assign bus.cpu_ren    = cpu_ren_q;
  assign bus.cpu_raddr  = cpu_raddr_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_nway
// Purpose  : Scoreboard bench for icache_nway (2 ways, 64 sets, 128-bit lines).
//            Stimulus pushes expected events (bus request address, fetched
//            word with optional latency, invalidate done) into a queue; a
//            monitor pops and compares each event the DUT presents.
//            Memory word at address a is 0xC0DE0000 | a[15:0].
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_nway;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_nway_if #(.ADDR_W(32), .LINE_BITS(128)) bus ();

  icache_nway #(
    .WAYS(2), .SETS(64), .LINE_BITS(128), .ADDR_W(32)
  ) dut (
    .cpu_clk_i (clk),
    .cpu_rst_i (rst),
    .bus       (bus)
  );

  typedef struct {
    int          kind;   // 0 fetched word, 1 inv_done, 2 bus request
    logic [31:0] data;
    int          lat;    // expected cycles from issue, -1 = unchecked
  } exp_t;

  exp_t        q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          issue_cyc = 0;
  bit          auto_resp = 1'b1;
  logic [3:0]  prev_ren = 4'h0;
  logic [31:0] resp_addr;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return 32'hC0DE0000 | {16'h0000, a[15:0]};
  endfunction

  function automatic logic [127:0] mem_line(logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem_word(a + 32'(4 * i));
    return l;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(int k, logic [31:0] d, int l);
    exp_t e;
    e.kind = k; e.data = d; e.lat = l;
    q.push_back(e);
  endtask

  task automatic take(int k, logic [31:0] d, string nm);
    exp_t e;
    if (q.size() == 0) begin
      n_total++;
      $display("FAIL %s: unexpected event with data %h, nothing expected", nm, d);
    end else begin
      e = q.pop_front();
      check({nm, "_kind"}, 32'(k), 32'(e.kind));
      if (e.kind == k) begin
        if (k != 1) check(nm, d, e.data);
        if (e.lat >= 0) check({nm, "_lat"}, 32'(cyc - issue_cyc), 32'(e.lat));
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cpu_ren == 4'hF && prev_ren != 4'hF) take(2, bus.cpu_raddr, "bus_req");
      if (bus.inst_valid) take(0, bus.inst_out, "inst");
      if (bus.inv_done)   take(1, 32'h0, "inv_done");
    end
    prev_ren = bus.cpu_ren;
  end

  // Bus responder: accept after 2 cycles, return the line 2 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_resp && !rst && bus.cpu_ren == 4'hF) begin
        resp_addr = bus.cpu_raddr;
        repeat (2) @(negedge clk);
        bus.dev_rrdy = 1'b1;
        @(negedge clk);
        bus.dev_rrdy = 1'b0;
        repeat (2) @(negedge clk);
        bus.dev_rdata  = mem_line(resp_addr);
        bus.dev_rvalid = 1'b1;
        @(negedge clk);
        bus.dev_rvalid = 1'b0;
      end
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!bus.inst_valid && n < 100) begin @(negedge clk); n++; end
    if (!bus.inst_valid) begin
      n_total++;
      $display("FAIL inst_timeout: got no inst_valid expected within 100 cycles");
    end
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic fetch(logic [31:0] a, bit unc, bit miss, logic [31:0] raddr,
                       logic [31:0] word, int lat);
    if (miss) push(2, raddr, -1);
    push(0, word, lat);
    bus.inst_addr = a; bus.uncached = unc; bus.inst_rreq = 1'b1;
    issue_cyc = cyc;
    @(negedge clk);
    bus.inst_rreq = 1'b0; bus.uncached = 1'b0;
    wait_valid();
  endtask

  task automatic wait_inv_done();
    int n = 0;
    while (!bus.inv_done && n < 20) begin @(negedge clk); n++; end
    if (!bus.inv_done) begin
      n_total++;
      $display("FAIL inv_timeout: got no inv_done expected within 20 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bus.inst_rreq = 1'b0; bus.inst_addr = '0; bus.uncached = 1'b0;
    bus.inv_req = 1'b0; bus.dev_rrdy = 1'b0; bus.dev_rvalid = 1'b0;
    bus.dev_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst_inst_out",   bus.inst_out,        32'h0);
    check("rst_inv_done",   32'(bus.inv_done),   32'h0);
    check("rst_cpu_ren",    32'(bus.cpu_ren),    32'h0);
    check("rst_cpu_raddr",  bus.cpu_raddr,       32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, critical word w2; then hit on w3 with 2-cycle latency
    fetch(32'h1C000008, 1'b0, 1'b1, 32'h1C000000, 32'hC0DE0008, -1);
    fetch(32'h1C00000C, 1'b0, 1'b0, 32'h0,        32'hC0DE000C, 2);

    // Invalidate concurrent with a fetch: invalidate first, fetch then misses
    push(1, 32'h0, -1);
    push(2, 32'h1C000000, -1);
    push(0, 32'hC0DE000C, -1);
    bus.inv_req = 1'b1; bus.inst_rreq = 1'b1; bus.inst_addr = 32'h1C00000C;
    wait_inv_done();
    bus.inv_req = 1'b0;
    @(negedge clk);
    bus.inst_rreq = 1'b0;
    wait_valid();

    // Standalone invalidate to start replacement checks from a clean cache
    push(1, 32'h0, -1);
    bus.inv_req = 1'b1;
    wait_inv_done();
    bus.inv_req = 1'b0;
    @(negedge clk);

    // Set 0 round-robin: A,B fill ways 0,1; C evicts way 0 (rr 0->1)
    fetch(32'h1C000000, 1'b0, 1'b1, 32'h1C000000, 32'hC0DE0000, -1);
    fetch(32'h1C000400, 1'b0, 1'b1, 32'h1C000400, 32'hC0DE0400, -1);
    fetch(32'h1C000800, 1'b0, 1'b1, 32'h1C000800, 32'hC0DE0800, -1);
    fetch(32'h1C000400, 1'b0, 1'b0, 32'h0,        32'hC0DE0400, 2);
    // A misses and replaces way 1 (B), rr 1->0
    fetch(32'h1C000000, 1'b0, 1'b1, 32'h1C000000, 32'hC0DE0000, -1);
    fetch(32'h1C000800, 1'b0, 1'b0, 32'h0,        32'hC0DE0800, 2);
    // B was evicted and now replaces way 0 (C)
    fetch(32'h1C000400, 1'b0, 1'b1, 32'h1C000400, 32'hC0DE0400, -1);

    // Uncached bypass: word address, no fill, later cached fetch misses
    fetch(32'h1C000010, 1'b1, 1'b1, 32'h1C000010, 32'hC0DE0010, -1);
    fetch(32'h1C000014, 1'b0, 1'b1, 32'h1C000010, 32'hC0DE0014, -1);
    fetch(32'h1C000018, 1'b0, 1'b0, 32'h0,        32'hC0DE0018, 2);

    // Reset in MISS_WAIT abandons the fetch
    auto_resp = 1'b0;
    push(2, 32'h1C000020, -1);
    bus.inst_addr = 32'h1C000024; bus.inst_rreq = 1'b1;
    @(negedge clk);
    bus.inst_rreq = 1'b0;
    n = 0;
    while (bus.cpu_ren != 4'hF && n < 20) begin @(negedge clk); n++; end
    check("t6_ren_seen", 32'(bus.cpu_ren), 32'hF);
    bus.dev_rrdy = 1'b1;
    @(negedge clk);
    bus.dev_rrdy = 1'b0;
    check("t6_ren_dropped", 32'(bus.cpu_ren), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.dev_rdata = mem_line(32'h1C000020);
    bus.dev_rvalid = 1'b1;
    @(negedge clk);
    bus.dev_rvalid = 1'b0;
    rst = 1'b0;
    check("t6_inst_valid", 32'(bus.inst_valid), 32'h0);
    check("t6_inst_out",   bus.inst_out,        32'h0);
    check("t6_cpu_ren",    32'(bus.cpu_ren),    32'h0);
    check("t6_cpu_raddr",  bus.cpu_raddr,       32'h0);
    // Late data in IDLE must be ignored
    bus.dev_rvalid = 1'b1;
    @(negedge clk);
    bus.dev_rvalid = 1'b0;
    check("t6_late_rvalid", 32'(bus.inst_valid), 32'h0);
    @(negedge clk);
    auto_resp = 1'b1;
    // Reset cleared all valid bits, and the abandoned line was not filled
    fetch(32'h1C00000C, 1'b0, 1'b1, 32'h1C000000, 32'hC0DE000C, -1);
    fetch(32'h1C000024, 1'b0, 1'b1, 32'h1C000020, 32'hC0DE0024, -1);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
